// File: rtl/instr_fetch_unit_pkg.sv
// Shared instruction-set constants, field widths and fetch FSM state encoding
// for the instruction fetch unit and anything that decodes its IR.
package instr_fetch_unit_pkg;

    localparam int OPC_W  = 6;
    localparam int OPER_W = 10;

    typedef logic [OPC_W-1:0] opcode_t;

    localparam opcode_t OP_FETCH  = 6'd0;
    localparam opcode_t OP_LDAC   = 6'd1;
    localparam opcode_t OP_CLAC   = 6'd2;
    localparam opcode_t OP_STAC   = 6'd3;
    localparam opcode_t OP_MVAC   = 6'd4;
    localparam opcode_t OP_ADD    = 6'd8;
    localparam opcode_t OP_SUB    = 6'd9;
    localparam opcode_t OP_INAC   = 6'd10;
    localparam opcode_t OP_AND    = 6'd16;
    localparam opcode_t OP_OR     = 6'd17;
    localparam opcode_t OP_XOR    = 6'd18;
    localparam opcode_t OP_NOT    = 6'd19;
    localparam opcode_t OP_LDII   = 6'd24;
    localparam opcode_t OP_NOP    = 6'd46;
    localparam opcode_t OP_JUMPNZ = 6'd47;
    localparam opcode_t OP_JUMPZ  = 6'd52;

    typedef enum logic [1:0] {
        S_ADDR = 2'd0,
        S_WAIT = 2'd1,
        S_EXEC = 2'd2,
        S_HALT = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives a registered instruction memory, loads IR,
// resolves conditional jumps locally and hands other instructions to execute.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int ADDR_W  = 9,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  address,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic               zero_flag,
    input  logic               exec_done,
    output logic [OPC_W-1:0]   opcode,
    output logic [OPER_W-1:0]  operand,
    output logic               instr_valid,
    output logic               halted,
    output logic [15:0]        retire_count,
    output ifu_state_t         fsm_state
);

    // Handshake: instr_valid=1 presents opcode/operand; the instruction is
    // consumed on the rising edge where instr_valid=1 and exec_done=1 are both seen.

    ifu_state_t         state;
    ifu_state_t         state_next;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;

    logic               is_jumpz;
    logic               is_jumpnz;
    logic               is_jump;
    logic               is_nop;
    logic               take_branch;
    logic [ADDR_W-1:0]  jump_target;
    logic [ADDR_W-1:0]  pc_next;
    logic               pc_load;
    logic               retire_evt;

    assign opcode    = ir[INSTR_W-1 -: OPC_W];
    assign operand   = ir[OPER_W-1:0];
    assign address   = pc;
    assign fsm_state = state;

    // Cast keeps only the low ADDR_W bits of the jump target.
    assign jump_target = ADDR_W'(operand);

    always_comb begin : branch_decision
        is_jumpz    = (opcode == OP_JUMPZ);
        is_jumpnz   = (opcode == OP_JUMPNZ);
        is_jump     = is_jumpz | is_jumpnz;
        is_nop      = (opcode == OP_NOP);
        take_branch = (is_jumpz && zero_flag) || (is_jumpnz && !zero_flag);
        pc_next     = take_branch ? jump_target : pc + ADDR_W'(1);
        pc_load     = (state == S_EXEC) && (is_jump || (!is_nop && exec_done));
        retire_evt  = (state == S_EXEC) && (is_jump || is_nop || exec_done);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_ADDR;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_ADDR: state_next = S_WAIT;
            S_WAIT: state_next = S_EXEC;
            S_EXEC: begin
                if (is_nop) begin
                    state_next = S_HALT;
                end else if (is_jump || exec_done) begin
                    state_next = S_ADDR;
                end
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_ADDR;
        endcase
    end

    always_comb begin
        instr_valid = (state == S_EXEC) && !is_jump && !is_nop;
        halted      = (state == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= '0;
            ir           <= '0;
            retire_count <= '0;
        end else begin
            if (state == S_WAIT) begin
                ir <= instr_in;
            end
            if (pc_load) begin
                pc <= pc_next;
            end
            if (retire_evt && retire_count != 16'hFFFF) begin
                retire_count <= retire_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a registered ROM model, walking
// straight-line, jump, wrap, halt and asynchronous-reset scenarios.
module tb_instr_fetch_unit;
    import instr_fetch_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  address;
    logic [15:0] instr_in = '0;
    logic        zero_flag = 1'b0;
    logic        exec_done = 1'b0;
    logic [5:0]  opcode;
    logic [9:0]  operand;
    logic        instr_valid;
    logic        halted;
    logic [15:0] retire_count;
    ifu_state_t  fsm_state;

    logic [15:0] rom [0:511];
    int          n_cmp = 0;
    int          n_mis = 0;

    instr_fetch_unit #(.ADDR_W(9), .INSTR_W(16)) dut (
        .clk(clk), .rst(rst), .address(address), .instr_in(instr_in),
        .zero_flag(zero_flag), .exec_done(exec_done), .opcode(opcode),
        .operand(operand), .instr_valid(instr_valid), .halted(halted),
        .retire_count(retire_count), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) instr_in <= rom[address];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic exec_step(input logic [8:0] pc, input logic [5:0] opc, input logic [9:0] oper,
                             input int hold, input logic [8:0] next_pc, input logic [15:0] ret);
        chk("exec_addr", address, pc);
        repeat (2) @(negedge clk);
        chk("valid_rise", instr_valid, 1);
        chk("opcode", opcode, opc);
        chk("operand", operand, oper);
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            chk("valid_hold", instr_valid, 1);
            chk("ir_stable", operand, oper);
            chk("addr_hold", address, pc);
        end
        exec_done = 1'b1;
        @(negedge clk);
        exec_done = 1'b0;
        chk("valid_drop", instr_valid, 0);
        chk("exec_next_addr", address, next_pc);
        chk("exec_retire", retire_count, ret);
    endtask

    task automatic jump_step(input logic [8:0] pc, input logic zf, input logic [8:0] next_pc,
                             input logic [15:0] ret);
        zero_flag = zf;
        chk("jump_addr", address, pc);
        repeat (2) @(negedge clk);
        chk("jump_state", 32'(fsm_state), 32'(S_EXEC));
        chk("jump_no_valid", instr_valid, 0);
        @(negedge clk);
        chk("jump_next_addr", address, next_pc);
        chk("jump_retire", retire_count, ret);
        chk("jump_state_after", 32'(fsm_state), 32'(S_ADDR));
    endtask

    task automatic nop_step(input logic [8:0] pc, input logic [15:0] ret);
        chk("nop_addr", address, pc);
        repeat (2) @(negedge clk);
        chk("nop_no_valid", instr_valid, 0);
        @(negedge clk);
        chk("halted", halted, 1);
        chk("halt_addr", address, pc);
        chk("nop_retire", retire_count, ret);
    endtask

    task automatic halt_hold(input logic [8:0] pc, input logic [15:0] ret);
        for (int i = 0; i < 100; i++) begin
            exec_done = (i % 7 == 0);
            @(negedge clk);
            chk("halt_addr_hold", address, pc);
            chk("halt_flag_hold", halted, 1);
            chk("halt_retire_frozen", retire_count, ret);
            chk("halt_no_valid", instr_valid, 0);
        end
        exec_done = 1'b0;
    endtask

    // Asserts rst away from a clock edge and checks outputs before any edge.
    task automatic reset_now();
        rst = 1'b1;
        #1;
        chk("rst_address", address, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_operand", operand, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_retire", retire_count, 0);
        chk("rst_state", 32'(fsm_state), 32'(S_ADDR));
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) rom[i] = {OP_NOP, 10'd0};
        rom[0]   = {OP_CLAC,   10'd0};
        rom[1]   = {OP_LDII,   10'd910};
        rom[2]   = {OP_JUMPZ,  10'd5};
        rom[3]   = {OP_NOP,    10'd0};
        rom[5]   = {OP_JUMPZ,  10'd169};
        rom[6]   = {OP_JUMPZ,  10'd10};
        rom[10]  = {OP_JUMPNZ, 10'd63};
        rom[11]  = {OP_JUMPZ,  10'd3};
        rom[63]  = {OP_JUMPNZ, 10'd3};
        rom[169] = {OP_JUMPZ,  10'd1023};
        rom[511] = {OP_ADD,    10'd0};

        repeat (2) @(negedge clk);
        chk("init_address", address, 0);
        chk("init_valid", instr_valid, 0);
        chk("init_halted", halted, 0);
        chk("init_retire", retire_count, 0);
        chk("init_opcode", opcode, 0);
        rst = 1'b0;

        // Run 1: taken jumps, truncated target, wrap 511 -> 0, reset mid-execute.
        exec_step(9'd0, OP_CLAC, 10'd0, 3, 9'd1, 16'd1);
        exec_step(9'd1, OP_LDII, 10'd910, 2, 9'd2, 16'd2);
        jump_step(9'd2, 1'b1, 9'd5, 16'd3);
        jump_step(9'd5, 1'b1, 9'd169, 16'd4);
        jump_step(9'd169, 1'b1, 9'd511, 16'd5);
        exec_step(9'd511, OP_ADD, 10'd0, 2, 9'd0, 16'd6);
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", instr_valid, 1);
        chk("pre_rst_opcode", opcode, OP_CLAC);
        #3;
        reset_now();

        // Run 2: not-taken JUMPZ, taken JUMPNZ, NOP halt held 100 cycles.
        exec_step(9'd0, OP_CLAC, 10'd0, 1, 9'd1, 16'd1);
        exec_step(9'd1, OP_LDII, 10'd910, 1, 9'd2, 16'd2);
        jump_step(9'd2, 1'b1, 9'd5, 16'd3);
        jump_step(9'd5, 1'b0, 9'd6, 16'd4);
        jump_step(9'd6, 1'b1, 9'd10, 16'd5);
        jump_step(9'd10, 1'b0, 9'd63, 16'd6);
        jump_step(9'd63, 1'b0, 9'd3, 16'd7);
        nop_step(9'd3, 16'd8);
        halt_hold(9'd3, 16'd8);
        #2;
        reset_now();

        // Run 3: not-taken JUMPNZ after leaving halt through reset.
        exec_step(9'd0, OP_CLAC, 10'd0, 1, 9'd1, 16'd1);
        exec_step(9'd1, OP_LDII, 10'd910, 1, 9'd2, 16'd2);
        jump_step(9'd2, 1'b1, 9'd5, 16'd3);
        jump_step(9'd5, 1'b0, 9'd6, 16'd4);
        jump_step(9'd6, 1'b1, 9'd10, 16'd5);
        jump_step(9'd10, 1'b1, 9'd11, 16'd6);
        jump_step(9'd11, 1'b1, 9'd3, 16'd7);
        nop_step(9'd3, 16'd8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
